// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider, quotient only, signed/unsigned, valid/ready in and out.
// Optional OPDIV_EARLY_OUT_EN finishes divide-by-zero and |a|<|b| two edges after accept.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signal_division,
    output logic [WIDTH-1:0] c,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    localparam int KW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, INIT, LOOP, FIX, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_mag, b_mag, rem_q, quo_q, rem_lo;
    logic [KW-1:0]    k_q;
    logic             uns_q, neg_q, ge, last, early;
    // Remainder compare uses one extra bit so large unsigned divisors stay exact.
    always_comb begin
        ge     = {rem_q, a_mag[WIDTH-1]} >= {1'b0, b_mag};
        rem_lo = {rem_q[WIDTH-2:0], a_mag[WIDTH-1]};
        last   = k_q == KW'(WIDTH - 1);
`ifdef OPDIV_EARLY_OUT_EN
        early  = (k_q == '0) && (b_mag == '0 || a_mag < b_mag);
`else
        early  = 1'b0;
`endif
    end
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid_i ? INIT : IDLE;
            INIT:    state_nxt = LOOP;
            LOOP:    state_nxt = early ? DONE : last ? FIX : LOOP;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = out_ready_i ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        in_ready_o  = (state == IDLE) && nreset;
        out_valid_o = state == DONE;
    end
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            a_q   <= '0;
            b_q   <= '0;
            uns_q <= 1'b0;
            a_mag <= '0;
            b_mag <= '0;
            neg_q <= 1'b0;
            rem_q <= '0;
            quo_q <= '0;
            k_q   <= '0;
            c     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    a_q   <= a;
                    b_q   <= b;
                    uns_q <= signal_division;
                end
                INIT: begin
                    a_mag <= (!uns_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    b_mag <= (!uns_q && b_q[WIDTH-1]) ? -b_q : b_q;
                    neg_q <= !uns_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rem_q <= '0;
                    quo_q <= '0;
                    k_q   <= '0;
                end
                LOOP: begin
                    a_mag <= a_mag << 1;
                    rem_q <= ge ? rem_lo - b_mag : rem_lo;
                    quo_q <= {quo_q[WIDTH-2:0], ge};
                    k_q   <= k_q + 1'b1;
                    if (early) c <= (b_mag == '0) ? '1 : '0;
                end
                FIX: c <= (b_mag == '0) ? '1 : neg_q ? -quo_q : quo_q;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed checks of the iterative divider (default build, full latency).
module tb_iter_divider;
    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        signal_division = 1'b0;
    logic [31:0] c;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    iter_divider #(.WIDTH(32)) dut (
        .clock(clock), .nreset(nreset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a(a), .b(b), .signal_division(signal_division), .c(c),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sd,
                         input logic ordy, input logic hold,
                         output logic [31:0] res, output int lat, output int acc);
        int n = 0;
        while (!in_ready_o && n < 200) begin
            @(posedge clock); #1; n++;
        end
        a = av; b = bv; signal_division = sd; in_valid_i = 1'b1; out_ready_i = ordy;
        @(posedge clock); #1;
        acc = cyc;
        if (!hold) in_valid_i = 1'b0;
        a = ~av; b = ~bv;
        lat = 0;
        while (!out_valid_o && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        res = c;
    endtask

    task automatic test_reset;
        #2;
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_o); end
        total++; if (c !== 32'h0) begin bad++; $display("FAIL reset_c got=%h want=00000000", c); end
        @(posedge clock); #3 nreset = 1'b1;
        @(posedge clock); #1;
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready_o); end
    endtask

    task automatic test_basic;
        logic [31:0] r; int lat, acc;
        do_op(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, r, lat, acc);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL basic_c got=%h want=00000000", r); end
        total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency got=%0d want=34", lat); end
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL basic_ready_in_done got=%b want=0", in_ready_o); end
        @(posedge clock); #1;
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", in_ready_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b want=0", out_valid_o); end
    endtask

    task automatic test_stream;
        logic [31:0] sa [6] = '{32'd100, 32'd1024, 32'd0, 32'd1000, 32'd511, 32'd1023};
        logic [31:0] sb [6] = '{32'd7, 32'd512, 32'd5, 32'd3, 32'd512, 32'd1};
        logic [31:0] sq [6] = '{32'd14, 32'd2, 32'd0, 32'd333, 32'd0, 32'd1023};
        logic [31:0] r; int lat, acc, prev;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            do_op(sa[i], sb[i], 1'b0, 1'b1, 1'b1, r, lat, acc);
            total++; if (r !== sq[i]) begin bad++; $display("FAIL stream_%0d got=%h want=%h", i, r, sq[i]); end
            if (prev >= 0) begin
                total++; if (acc - prev !== 36) begin bad++; $display("FAIL stream_period_%0d got=%0d want=36", i, acc - prev); end
            end
            prev = acc;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_signs;
        logic [31:0] sa [5] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] sb [5] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd2};
        logic [31:0] sq [5] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'h80000000, 32'hFFFFFFFD};
        logic [31:0] r; int lat, acc;
        for (int i = 0; i < 5; i++) begin
            do_op(sa[i], sb[i], 1'b0, 1'b1, 1'b0, r, lat, acc);
            total++; if (r !== sq[i]) begin bad++; $display("FAIL signed_%0d got=%h want=%h", i, r, sq[i]); end
        end
    endtask

    task automatic test_unsigned;
        logic [31:0] sa [3] = '{32'hFFFFFFFF, 32'hFFFFFF9C, 32'hFFFFFFFF};
        logic [31:0] sb [3] = '{32'd2, 32'd7, 32'h80000001};
        logic [31:0] sq [3] = '{32'h7FFFFFFF, 32'h24924916, 32'd1};
        logic [31:0] r; int lat, acc;
        for (int i = 0; i < 3; i++) begin
            do_op(sa[i], sb[i], 1'b1, 1'b1, 1'b0, r, lat, acc);
            total++; if (r !== sq[i]) begin bad++; $display("FAIL unsigned_%0d got=%h want=%h", i, r, sq[i]); end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] sa [4] = '{32'd5, 32'hFFFFFFFB, 32'd0, 32'h12345678};
        logic        sm [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] r; int lat, acc;
        for (int i = 0; i < 4; i++) begin
            do_op(sa[i], 32'd0, sm[i], 1'b1, 1'b0, r, lat, acc);
            total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_%0d got=%h want=ffffffff", i, r); end
            total++; if (lat !== 34) begin bad++; $display("FAIL div0_latency_%0d got=%0d want=34", i, lat); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r; int lat, acc;
        do_op(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, r, lat, acc);
        total++; if (r !== 32'd333) begin bad++; $display("FAIL bp_c got=%h want=0000014d", r); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            total++; if (out_valid_o !== 1'b1 || c !== 32'd333 || in_ready_o !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d valid=%b c=%h ready=%b want valid=1 c=0000014d ready=0", i, out_valid_o, c, in_ready_o);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clock); #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid_o); end
        total++; if (c !== 32'd333) begin bad++; $display("FAIL bp_retain_c got=%h want=0000014d", c); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; int lat, acc;
        a = 32'd77; b = 32'd5; signal_division = 1'b0; in_valid_i = 1'b1;
        @(posedge clock); #1;
        in_valid_i = 1'b0;
        repeat (10) @(posedge clock);
        #2 nreset = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid_o); end
        total++; if (c !== 32'h0) begin bad++; $display("FAIL rst_mid_c got=%h want=00000000", c); end
        repeat (2) @(posedge clock);
        #3 nreset = 1'b1;
        @(posedge clock); #1;
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", in_ready_o); end
        do_op(32'd9, 32'd3, 1'b0, 1'b1, 1'b0, r, lat, acc);
        total++; if (r !== 32'd3) begin bad++; $display("FAIL rst_mid_fresh got=%h want=00000003", r); end
        total++; if (lat !== 34) begin bad++; $display("FAIL rst_mid_latency got=%0d want=34", lat); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stream;
        test_signs;
        test_unsigned;
        test_div_zero;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
